// File: rtl/dp_mem_responder.sv
// Single-port-per-side memory responder: serialises instruction and data
// accesses with a fixed request-to-hit latency, plus a backdoor preload port.
module dp_mem_responder #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  input  logic        ldWEN,
  input  logic [31:0] ldaddr,
  input  logic [31:0] lddata,
  output logic        halted,
  output logic [31:0] icount,
  output logic [31:0] dcount
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, HALTED} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic        lat_wr;

  logic [31:0]       mem [0:(1 << ADDR_W) - 1];
  logic [ADDR_W-1:0] acc_idx;
  logic [ADDR_W-1:0] ld_idx;

  logic d_req;
  logic i_abort;
  logic d_abort;
  logic unused_ld_bits;

  assign acc_idx = lat_addr[ADDR_W+1:2];
  assign ld_idx  = ldaddr[ADDR_W+1:2];
  assign unused_ld_bits = ^{ldaddr[31:ADDR_W+2], ldaddr[1:0]};

  assign d_req   = dmemREN | dmemWEN;
  assign i_abort = !imemREN || (imemaddr != lat_addr);
  assign d_abort = !d_req || (dmemWEN != lat_wr) || (dmemaddr != lat_addr);

  // Hit is suppressed in the same cycle as a reset, halt or abort condition.
  assign ihit = !RST && !halt && (state == BUSY_I) && (cnt == '0) && !i_abort;
  assign dhit = !RST && !halt && (state == BUSY_D) && (cnt == '0) && !d_abort;

  assign imemload = ihit ? mem[acc_idx] : '0;
  assign dmemload = dhit ? mem[acc_idx] : '0;
  assign halted   = (state == HALTED);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      icount   <= '0;
      dcount   <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_wr   <= 1'b0;
    end else begin
      if (ihit) icount <= icount + 32'd1;
      if (dhit) dcount <= dcount + 32'd1;
      if (halt) begin
        state <= HALTED;
      end else begin
        case (state)
          IDLE: begin
            if (d_req) begin
              lat_wr   <= dmemWEN;
              lat_addr <= dmemaddr;
              lat_data <= dmemstore;
              cnt      <= CNT_INIT;
              state    <= BUSY_D;
            end else if (imemREN) begin
              lat_addr <= imemaddr;
              cnt      <= CNT_INIT;
              state    <= BUSY_I;
            end
          end
          BUSY_I: begin
            if (i_abort || cnt == '0) state <= IDLE;
            else                      cnt   <= cnt - 4'd1;
          end
          BUSY_D: begin
            if (d_abort || cnt == '0) state <= IDLE;
            else                      cnt   <= cnt - 4'd1;
          end
          default: state <= HALTED;
        endcase
      end
    end
  end

  // Memory is never reset; the later assignment lets a committing data write
  // override a same-word backdoor load on the same edge.
  always_ff @(posedge CLK) begin
    if (ldWEN)          mem[ld_idx]  <= lddata;
    if (dhit && lat_wr) mem[acc_idx] <= lat_data;
  end

endmodule

// File: tb/tb_dp_mem_responder.sv
// Directed self-checking bench for dp_mem_responder (LATENCY=2, ADDR_W=8).
module tb_dp_mem_responder;

  logic        CLK = 1'b0;
  logic        RST, halt;
  logic        imemREN, dmemREN, dmemWEN, ldWEN;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ldaddr, lddata;
  logic [31:0] imemload, dmemload, icount, dcount;
  logic        ihit, dhit, halted;

  int total = 0;
  int bad   = 0;
  int exp_ic = 0;
  int exp_dc = 0;

  dp_mem_responder #(.LATENCY(2), .ADDR_W(8)) dut (
    .CLK(CLK), .RST(RST), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
    .ldWEN(ldWEN), .ldaddr(ldaddr), .lddata(lddata),
    .halted(halted), .icount(icount), .dcount(dcount)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drives a data request until its dhit (bounded), returning hit cycle and load.
  task automatic d_access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int hit_at,
                          output logic [31:0] load);
    dmemREN = rd; dmemWEN = wr; dmemaddr = a; dmemstore = d;
    hit_at = -1; load = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (dhit) begin hit_at = c; load = dmemload; end
      step();
      if (hit_at >= 0) break;
    end
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  task automatic i_access(input logic [31:0] a, output int hit_at,
                          output logic [31:0] load);
    imemREN = 1'b1; imemaddr = a;
    hit_at = -1; load = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (ihit) begin hit_at = c; load = imemload; end
      step();
      if (hit_at >= 0) break;
    end
    imemREN = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] pa [7] = '{32'h40, 32'h44, 32'h0, 32'h100, 32'h200, 32'h300, 32'h80};
    logic [31:0] pd [7] = '{32'h8C220004, 32'h44444444, 32'h11111111, 32'h12345678,
                            32'hA5A5A5A5, 32'h33333333, 32'h00000080};
    RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; dmemREN = 1'b1; dmemaddr = 32'h100;
    for (int k = 0; k < 7; k++) begin
      ldWEN = 1'b1; ldaddr = pa[k]; lddata = pd[k];
      @(negedge CLK);
      total++;
      if ({ihit, dhit, halted} !== 3'b000 || imemload !== 32'h0 || dmemload !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs: got hits/halted=%b loads=%h/%h want 000 and 0/0",
                 {ihit, dhit, halted}, imemload, dmemload);
      end
      step();
    end
    ldWEN = 1'b0; RST = 1'b0; imemREN = 1'b0; dmemREN = 1'b0;
    @(negedge CLK);
    total++;
    if (icount !== 32'd0 || dcount !== 32'd0 || halted !== 1'b0 || ihit !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got icount=%0d dcount=%0d halted=%b ihit=%b want 0 0 0 0",
               icount, dcount, halted, ihit);
    end
    step();
  endtask

  task automatic test_ifetch();
    imemREN = 1'b1; imemaddr = 32'h40;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      total++;
      if (ihit !== (c == 2) || imemload !== ((c == 2) ? 32'h8C220004 : 32'h0)) begin
        bad++;
        $display("FAIL ifetch_c%0d: got ihit=%b load=%h want ihit=%b load=%h", c, ihit,
                 imemload, (c == 2), (c == 2) ? 32'h8C220004 : 32'h0);
      end
      step();
      if (c == 2) imemREN = 1'b0;
    end
    exp_ic++;
    @(negedge CLK);
    total++;
    if (icount !== exp_ic) begin
      bad++;
      $display("FAIL ifetch_icount: got %0d want %0d", icount, exp_ic);
    end
    step();
  endtask

  task automatic test_dwrite_read();
    int h; logic [31:0] v;
    d_access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, h, v);
    total++;
    if (h != 2 || v !== 32'h12345678) begin
      bad++;
      $display("FAIL dwrite: got hit_at=%0d load=%h want 2 12345678", h, v);
    end
    d_access(1'b1, 1'b0, 32'h100, 32'h0, h, v);
    total++;
    if (h != 2 || v !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL dread: got hit_at=%0d load=%h want 2 deadbeef", h, v);
    end
    exp_dc += 2;
    @(negedge CLK);
    total++;
    if (dcount !== exp_dc || dhit !== 1'b0) begin
      bad++;
      $display("FAIL dwr_dcount: got dcount=%0d dhit=%b want %0d 0", dcount, dhit, exp_dc);
    end
    step();
  endtask

  task automatic test_priority();
    imemREN = 1'b1; imemaddr = 32'h40; dmemREN = 1'b1; dmemaddr = 32'h100;
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK);
      total++;
      if (dhit !== (c == 2) || ihit !== (c == 5) ||
          dmemload !== ((c == 2) ? 32'hDEADBEEF : 32'h0) ||
          imemload !== ((c == 5) ? 32'h8C220004 : 32'h0)) begin
        bad++;
        $display("FAIL priority_c%0d: got dhit=%b ihit=%b dl=%h il=%h want dhit=%b ihit=%b",
                 c, dhit, ihit, dmemload, imemload, (c == 2), (c == 5));
      end
      step();
      if (c == 2) dmemREN = 1'b0;
      if (c == 5) imemREN = 1'b0;
    end
    exp_dc++; exp_ic++;
  endtask

  task automatic test_abort();
    int h; logic [31:0] v;
    dmemWEN = 1'b1; dmemaddr = 32'h200; dmemstore = 32'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      total++;
      if (dhit !== 1'b0) begin
        bad++;
        $display("FAIL abort_wen_c%0d: got dhit=%b want 0", c, dhit);
      end
      step();
      if (c == 0) dmemWEN = 1'b0;
    end
    d_access(1'b1, 1'b0, 32'h200, 32'h0, h, v);
    total++;
    if (h != 2 || v !== 32'hA5A5A5A5) begin
      bad++;
      $display("FAIL abort_mem: got hit_at=%0d load=%h want 2 a5a5a5a5", h, v);
    end
    exp_dc++;
    imemREN = 1'b1; imemaddr = 32'h40;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      total++;
      if (ihit !== (c == 4) || imemload !== ((c == 4) ? 32'h44444444 : 32'h0)) begin
        bad++;
        $display("FAIL abort_addr_c%0d: got ihit=%b load=%h want ihit=%b", c, ihit,
                 imemload, (c == 4));
      end
      step();
      if (c == 0) imemaddr = 32'h44;
      if (c == 4) imemREN = 1'b0;
    end
    exp_ic++;
    @(negedge CLK);
    total++;
    if (dcount !== exp_dc || icount !== exp_ic) begin
      bad++;
      $display("FAIL abort_counts: got i=%0d d=%0d want i=%0d d=%0d", icount, dcount,
               exp_ic, exp_dc);
    end
    step();
  endtask

  task automatic test_rw_both();
    int h; logic [31:0] v;
    d_access(1'b1, 1'b1, 32'h300, 32'h0BADF00D, h, v);
    total++;
    if (h != 2 || v !== 32'h33333333) begin
      bad++;
      $display("FAIL rw_both: got hit_at=%0d load=%h want 2 33333333", h, v);
    end
    d_access(1'b1, 1'b0, 32'h300, 32'h0, h, v);
    total++;
    if (v !== 32'h0BADF00D) begin
      bad++;
      $display("FAIL rw_both_rb: got %h want 0badf00d", v);
    end
    exp_dc += 2;
  endtask

  task automatic test_alias();
    int h; logic [31:0] v;
    d_access(1'b1, 1'b0, 32'h402, 32'h0, h, v);
    total++;
    if (h != 2 || v !== 32'h11111111) begin
      bad++;
      $display("FAIL alias_d: got hit_at=%0d load=%h want 2 11111111", h, v);
    end
    i_access(32'h441, h, v);
    total++;
    if (h != 2 || v !== 32'h8C220004) begin
      bad++;
      $display("FAIL alias_i: got hit_at=%0d load=%h want 2 8c220004", h, v);
    end
    exp_dc++; exp_ic++;
  endtask

  task automatic test_ld_collision();
    int h; logic [31:0] v;
    dmemWEN = 1'b1; dmemaddr = 32'h80; dmemstore = 32'hCAFE0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      total++;
      if (dhit !== (c == 2) || dmemload !== ((c == 2) ? 32'h00000080 : 32'h0)) begin
        bad++;
        $display("FAIL collide_c%0d: got dhit=%b load=%h want dhit=%b", c, dhit,
                 dmemload, (c == 2));
      end
      step();
      if (c == 1) begin ldWEN = 1'b1; ldaddr = 32'h80; lddata = 32'h55555555; end
      if (c == 2) begin ldWEN = 1'b0; dmemWEN = 1'b0; end
    end
    d_access(1'b1, 1'b0, 32'h80, 32'h0, h, v);
    total++;
    if (v !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL collide_rb: got %h want cafe0001", v);
    end
    exp_dc += 2;
  endtask

  task automatic test_halt();
    int h; logic [31:0] v;
    imemREN = 1'b1; imemaddr = 32'h40;
    for (int c = 0; c < 7; c++) begin
      @(negedge CLK);
      total++;
      if (ihit !== 1'b0 || halted !== (c >= 3)) begin
        bad++;
        $display("FAIL halt_c%0d: got ihit=%b halted=%b want 0 %b", c, ihit, halted, (c >= 3));
      end
      step();
      if (c == 1) halt = 1'b1;
      if (c == 2) halt = 1'b0;
    end
    @(negedge CLK);
    total++;
    if (icount !== exp_ic || dcount !== exp_dc) begin
      bad++;
      $display("FAIL halt_counts: got i=%0d d=%0d want i=%0d d=%0d", icount, dcount,
               exp_ic, exp_dc);
    end
    step();
    RST = 1'b1; imemREN = 1'b0;
    step();
    RST = 1'b0;
    exp_ic = 0; exp_dc = 0;
    @(negedge CLK);
    total++;
    if (halted !== 1'b0 || icount !== 32'd0 || dcount !== 32'd0) begin
      bad++;
      $display("FAIL halt_reset: got halted=%b i=%0d d=%0d want 0 0 0", halted, icount, dcount);
    end
    step();
    i_access(32'h40, h, v);
    total++;
    if (h != 2 || v !== 32'h8C220004) begin
      bad++;
      $display("FAIL halt_mem_i: got hit_at=%0d load=%h want 2 8c220004", h, v);
    end
    d_access(1'b1, 1'b0, 32'h100, 32'h0, h, v);
    total++;
    if (h != 2 || v !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL halt_mem_d: got hit_at=%0d load=%h want 2 deadbeef", h, v);
    end
    exp_ic++; exp_dc++;
    @(negedge CLK);
    total++;
    if (icount !== exp_ic || dcount !== exp_dc) begin
      bad++;
      $display("FAIL post_reset_counts: got i=%0d d=%0d want i=%0d d=%0d", icount, dcount,
               exp_ic, exp_dc);
    end
    step();
  endtask

  initial begin
    RST = 1'b1; halt = 1'b0;
    imemREN = 1'b0; imemaddr = '0;
    dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
    ldWEN = 1'b0; ldaddr = '0; lddata = '0;
    step();
    test_reset();
    test_ifetch();
    test_dwrite_read();
    test_priority();
    test_abort();
    test_rw_both();
    test_alias();
    test_ld_collision();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
